// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake for uart_tx_frame: a word on data qualified by req,
// accepted on any rising edge where req && rdy.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 req;
    logic [DATA_BITS-1:0] data;
    logic                 rdy;

    modport master (output req, output data, input rdy);
    modport slave  (input req, input data, output rdy);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one-word holding register feeding a
// start/data/parity/stop serialiser with a bit period counted in clock cycles.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0
) (
    input  logic           clk,
    input  logic           clr,
    uart_tx_frame_if.slave tx_if,
    output logic           xmt,
    output logic           busy,
    output logic           done
);
    localparam int TICK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
            MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_params
            $fatal(1, "uart_tx_frame: illegal parameter value");
        end
    endgenerate

    logic [2:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;
    logic                 par_q, par_d;
    logic                 xmt_q, xmt_d;
    logic                 tick_last;
    logic                 stop_last;

    assign tick_last = (tick_q == TICK_W'(CLKS_PER_BIT - 1));
    assign stop_last = (bit_q == BIT_W'(STOP_BITS - 1));

    assign tx_if.rdy = !valid_q;
    assign xmt       = xmt_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_STOP) && tick_last && stop_last;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        par_d   = par_q;
        xmt_d   = 1'b1;

        // rdy is low whenever valid is set, so accept and transfer never collide
        if (tx_if.req && !valid_q) begin
            hold_d  = tx_if.data;
            valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
            end
            S_START: begin
                tick_d = tick_q + 1'b1;
                if (tick_last) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                tick_d = tick_q + 1'b1;
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = bit_q + 1'b1;
                    shift_d = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                               : {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end
                end
            end
            S_PARITY: begin
                tick_d = tick_q + 1'b1;
                if (tick_last) begin
                    state_d = S_STOP;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                tick_d = tick_q + 1'b1;
                if (tick_last) begin
                    tick_d = '0;
                    bit_d  = bit_q + 1'b1;
                    if (stop_last) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Word transfer: from IDLE, or straight out of the last stop cycle
        if (valid_q && (state_q == S_IDLE || (state_q == S_STOP && tick_last && stop_last))) begin
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = hold_q;
            par_d   = (^hold_q) ^ (PARITY == 2);
            valid_d = 1'b0;
        end

        // Line level is registered from the next state so xmt changes with the state
        case (state_d)
            S_START:  xmt_d = 1'b0;
            S_DATA:   xmt_d = (MSB_FIRST != 0) ? shift_d[DATA_BITS-1] : shift_d[0];
            S_PARITY: xmt_d = par_d;
            default:  xmt_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            xmt_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            par_q   <= par_d;
            xmt_q   <= xmt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameter sets, table-driven frames
// plus hand-written back-to-back, data-hold and mid-frame reset sequences.
module tb_uart_tx_frame;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req_r  [4];
    logic [7:0] data_r [4];
    logic [3:0] xmt_w, busy_w, done_w, rdy_w;

    int n_cmp = 0;
    int n_mis = 0;

    logic cap_xmt  [0:255];
    logic cap_busy [0:255];
    logic cap_done [0:255];
    logic cap_rdy  [0:255];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 MSB first
    uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_b ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_c ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_d ();

    assign if_a.req = req_r[0];  assign if_a.data = data_r[0];  assign rdy_w[0] = if_a.rdy;
    assign if_b.req = req_r[1];  assign if_b.data = data_r[1];  assign rdy_w[1] = if_b.rdy;
    assign if_c.req = req_r[2];  assign if_c.data = data_r[2];  assign rdy_w[2] = if_c.rdy;
    assign if_d.req = req_r[3];  assign if_d.data = data_r[3];  assign rdy_w[3] = if_d.rdy;

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .clr(clr), .tx_if(if_a),
        .xmt(xmt_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut_b (
        .clk(clk), .clr(clr), .tx_if(if_b),
        .xmt(xmt_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_c (
        .clk(clk), .clr(clr), .tx_if(if_c),
        .xmt(xmt_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .MSB_FIRST(1)) dut_d (
        .clk(clk), .clr(clr), .tx_if(if_d),
        .xmt(xmt_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    typedef struct {
        int         dut;
        logic [7:0] word;
        string      line;   // expected line levels, one char per bit period
        string      name;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic capture(input int d, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            @(negedge clk);
            cap_xmt[k]  = xmt_w[d];
            cap_busy[k] = busy_w[d];
            cap_done[k] = done_w[d];
            cap_rdy[k]  = rdy_w[d];
        end
    endtask

    task automatic wait_rdy(input int d, input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy_w[d] === 1'b1) break;
        end
        if (k == 200) chk({nm, " rdy timeout"}, 0, 1);
    endtask

    // Reports the first capture index whose level differs from the expected line
    task automatic check_line(input int off, input string line, input string nm);
        int bad;
        logic e;
        bad = -1;
        for (int j = 0; j < line.len(); j++) begin
            e = (line[j] == "1");
            for (int t = 0; t < CPB; t++)
                if (bad < 0 && cap_xmt[off + j*CPB + t] !== e) bad = j*CPB + t;
        end
        chk({nm, " first bad sample"}, bad, -1);
    endtask

    function automatic int count_high(input int which, input int from, input int to);
        int c;
        c = 0;
        for (int k = from; k < to; k++) begin
            if (which == 0 && cap_busy[k] === 1'b1) c++;
            if (which == 1 && cap_done[k] === 1'b1) c++;
        end
        return c;
    endfunction

    function automatic string frame_8n1(input logic [7:0] w);
        string s;
        s = "0";
        for (int i = 0; i < 8; i++) s = {s, w[i] ? "1" : "0"};
        s = {s, "1"};
        return s;
    endfunction

    task automatic send_vec(input vec_t v);
        int n;
        int last_done;
        n = v.line.len() * CPB;
        wait_rdy(v.dut, v.name);
        req_r[v.dut]  = 1'b1;
        data_r[v.dut] = v.word;
        @(posedge clk);                // E0: accept
        #1 req_r[v.dut] = 1'b0;
        data_r[v.dut] = 8'h00;
        @(posedge clk);                // E1: start bit
        #1;
        capture(v.dut, 0, n + 8);
        chk({v.name, " rdy at E1"}, int'(cap_rdy[0]), 1);
        check_line(0, v.line, v.name);
        chk({v.name, " busy cycles"}, count_high(0, 0, n + 8), n);
        chk({v.name, " done pulses"}, count_high(1, 0, n + 8), 1);
        last_done = -1;
        for (int k = 0; k < n + 8; k++) if (cap_done[k] === 1'b1) last_done = k;
        chk({v.name, " done position"}, last_done, n - 1);
    endtask

    initial begin
        logic [7:0] acc [$];
        int         first_acc;
        logic       rdy_now;
        int         bad;

        vecs[0]  = '{0, 8'hA5, "0101001011",  "8N1 A5"};
        vecs[1]  = '{0, 8'h00, "0000000001",  "8N1 00"};
        vecs[2]  = '{0, 8'hFF, "0111111111",  "8N1 FF"};
        vecs[3]  = '{1, 8'h07, "01110000011", "8E1 07"};
        vecs[4]  = '{1, 8'h00, "00000000001", "8E1 00"};
        vecs[5]  = '{2, 8'h07, "01110000001", "8O1 07"};
        vecs[6]  = '{2, 8'h00, "00000000011", "8O1 00"};
        vecs[7]  = '{3, 8'h80, "01000000011", "8N2 MSB 80"};
        vecs[8]  = '{3, 8'h01, "00000000111", "8N2 MSB 01"};
        vecs[9]  = '{3, 8'hC3, "01100001111", "8N2 MSB C3"};
        vecs[10] = '{0, 8'h3C, "0001111001",  "8N1 3C after clr"};

        for (int d = 0; d < 4; d++) begin
            req_r[d]  = 1'b0;
            data_r[d] = 8'h00;
        end

        // Reset values while clr is held, then after release
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++)
            chk($sformatf("reset dut%0d {xmt,rdy,busy,done}", d),
                int'({xmt_w[d], rdy_w[d], busy_w[d], done_w[d]}), 'b1100);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle after clr {xmt,rdy,busy,done}",
            int'({xmt_w[0], rdy_w[0], busy_w[0], done_w[0]}), 'b1100);

        for (int i = 0; i < 10; i++) send_vec(vecs[i]);

        // Back-to-back: 0x55 then 0xAA with req held across the first start bit
        wait_rdy(0, "b2b");
        req_r[0]  = 1'b1;
        data_r[0] = 8'h55;
        @(posedge clk);                // E0
        #1 data_r[0] = 8'hAA;
        @(posedge clk);                // E1
        #1;
        capture(0, 0, 1);
        @(posedge clk);                // E2: second accept
        #1 req_r[0] = 1'b0;
        capture(0, 1, 90);
        chk("b2b rdy at E1", int'(cap_rdy[0]), 1);
        bad = -1;
        for (int k = 1; k < 40; k++) if (bad < 0 && cap_rdy[k] !== 1'b0) bad = k;
        chk("b2b rdy low E2..second start, first bad", bad, -1);
        chk("b2b rdy at second start", int'(cap_rdy[40]), 1);
        check_line(0, {"0101010101", "0010101011"}, "b2b");
        chk("b2b busy cycles", count_high(0, 0, 91), 80);
        chk("b2b done pulses", count_high(1, 0, 91), 2);

        // Data toggles every cycle with req held: only accepted words reach the line
        repeat (4) @(negedge clk);
        first_acc = -1;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            cap_xmt[n] = xmt_w[0];
            rdy_now    = rdy_w[0];
            if (acc.size() < 2) begin
                req_r[0]  = 1'b1;
                data_r[0] = 8'(n * 37 + 5);
                if (rdy_now) begin
                    acc.push_back(data_r[0]);
                    if (first_acc < 0) first_acc = n;
                end
            end else begin
                req_r[0] = 1'b0;
            end
        end
        req_r[0] = 1'b0;
        chk("hold words accepted", acc.size(), 2);
        chk("hold first accept cycle", first_acc, 0);
        if (acc.size() == 2 && first_acc == 0)
            check_line(2, {frame_8n1(acc[0]), frame_8n1(acc[1])}, "hold");

        // Mid-frame clear during data bit 3 of 0xA5 (bit 3 is 0 on the line)
        wait_rdy(0, "clr");
        req_r[0]  = 1'b1;
        data_r[0] = 8'hA5;
        @(posedge clk);
        #1 req_r[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre-clr {xmt,busy}", int'({xmt_w[0], busy_w[0]}), 'b01);
        clr = 1'b1;
        #1;
        chk("async clr {xmt,rdy,busy,done}",
            int'({xmt_w[0], rdy_w[0], busy_w[0], done_w[0]}), 'b1100);
        @(negedge clk);
        clr = 1'b0;
        send_vec(vecs[10]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the next generation of the fixed 8-bit serial sender. It accepts a data word through a valid/ready handshake into a holding register, then serialises it with a start bit, DATA_BITS data bits, optional parity and 1 or 2 stop bits. Bit period is set directly in clock cycles. It sits between the host-side producer logic and the board TX pin.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per serial bit; legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- PARITY, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- MSB_FIRST, default 0: data bit order; 0 = LSB first, 1 = MSB first.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset; one clock, asynchronous, active-high.
- req  in  1  producer has a valid word on data.
- data  in  DATA_BITS  word to send; sampled only on an accept edge.
- rdy  out  1  holding register empty. A word is accepted on any rising edge with req && rdy.
- xmt  out  1  serial line, registered, idle high.
- busy  out  1  a frame is on the line; high from the start bit through the last stop bit.
- done  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset (clr high, asynchronous): xmt=1, rdy=1, busy=0, done=0. FSM goes to IDLE. Holding register is invalidated. Bit and tick counters go to 0. A frame in progress is abandoned with no glitch low.
- Holding register: one DATA_BITS-wide word plus a valid flag. rdy = !valid.
  - On an accept edge: the register loads data and valid sets.
  - valid clears on the edge where the FSM moves the word into the shift register.
  - An accept and a transfer on the same edge is impossible, because rdy=0 whenever valid=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: xmt=1. If valid, go to START on the next edge. At that edge, copy the word to the shift register and compute the parity bit. Even parity = XOR of the data bits; odd parity = its inverse.
  - START: xmt=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send DATA_BITS bits, each for CLKS_PER_BIT cycles. Order is LSB first, or MSB first when MSB_FIRST=1. After the last bit, go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: send the parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: xmt=1 for STOP_BITS×CLKS_PER_BIT cycles. In the final cycle, pulse done. If valid, go directly to START, loading the next word on that same edge. Otherwise go to IDLE.
- Tick counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT−1. Resets to 0 on every state or bit change. A bit advances when tick == CLKS_PER_BIT−1.
- Bit counter: width clog2(DATA_BITS+1). Counts data bits in DATA and stop bits in STOP; cleared on entry to each state.
- busy = (state ≠ IDLE).
- data changes while valid=1 have no effect on the frame.

## Timing
- Accept at edge E0 while IDLE:
  - At E1: xmt=0, busy=1, rdy=1.
  - The first data bit starts at E1+CLKS_PER_BIT.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, exact, with no extra cycles between bits.
- Back-to-back frames: if valid is set before the final STOP cycle, the next start bit begins on the edge right after done. There is zero idle time and busy stays 1.
- A word accepted during a frame waits in the holding register. rdy stays 0 until that word's start bit begins.
- done is high exactly one cycle per frame. It is coincident with the last stop cycle and is never asserted in IDLE.
- Reset asserted mid-frame: outputs take their reset values immediately. After clr deasserts, the first accept follows the E0/E1 rule above.
- Parameter values outside their legal ranges are a fatal elaboration error.

## Test plan
- Defaults except CLKS_PER_BIT=4; reset, then accept 0xA5 → xmt = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. busy is high for exactly 40 cycles. done pulses at cycle 40. rdy is 1 again at E1.
- CLKS_PER_BIT=4, PARITY=1: send 0x07 → parity bit is 1. PARITY=2: send 0x07 → parity bit is 0. Frame is 44 cycles in both cases.
- CLKS_PER_BIT=4, STOP_BITS=2, MSB_FIRST=1: send 0x80 → start 0, then 1, then seven 0s, then 1,1. Frame is 44 cycles.
- Back-to-back: accept 0x55 at E0 and 0xAA at E1 with req held → two 40-cycle frames with no idle gap. rdy=0 from E2 until the second start bit begins. Exactly two done pulses.
- Hold req=1 while rdy=0 with data changing every cycle → only the words sampled on accept edges appear on xmt.
- Assert clr for 1 cycle in the middle of data bit 3 → xmt=1, busy=0, rdy=1 immediately. A new 0x3C frame sent afterwards is correct.
